ami_rd_arb: RTL

- N-requester read scheduler in front of the AXI master read interface's user AR/R ports, in the usr_clk domain.
- Arbitrates AR requests round-robin and tags each forwarded ARID with the requester index.
- Enforces a per-requester outstanding-burst limit.
- Steers returning R beats back to the owning requester by decoding RID.

---
 rtl/ami_pkg.sv | 52 +++++
 rtl/ami_rr_arb.sv | 24 ++
 rtl/ami_rd_arb.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/ami_pkg.sv
// Shared types and helpers for the ami_rd_arb read scheduler: AR/R payload
// structs at the default AXI widths, the arbiter FSM state and the round-robin pick.
package ami_pkg;

   localparam int RR_MAXN = 32;

   localparam int DEF_IW     = 8;
   localparam int DEF_AW     = 32;
   localparam int DEF_LW     = 8;
   localparam int DEF_SW     = 3;
   localparam int DEF_BURSTW = 2;
   localparam int DEF_DW     = 128;
   localparam int DEF_RRESPW = 2;

   typedef struct packed {
      logic [DEF_IW-1:0]     id;
      logic [DEF_AW-1:0]     addr;
      logic [DEF_LW-1:0]     len;
      logic [DEF_SW-1:0]     size;
      logic [DEF_BURSTW-1:0] burst;
   } ar_pay_t;

   typedef struct packed {
      logic [DEF_IW-1:0]     id;
      logic [DEF_DW-1:0]     data;
      logic [DEF_RRESPW-1:0] resp;
      logic                  last;
   } r_pay_t;

   typedef enum logic {ARB, ISSUE} arb_state_t;

   // First set bit of req at or above ptr, wrapping within the low n bits.
   function automatic int rr_pick(input logic [RR_MAXN-1:0] req, input int ptr, input int n);
      int  pick;
      int  j;
      bit  found;
      pick  = 0;
      found = 1'b0;
      for (int k = 0; k < RR_MAXN; k++) begin
         if (k < n && !found) begin
            j = ptr + k;
            if (j >= n) j = j - n;
            if (req[j]) begin
               pick  = j;
               found = 1'b1;
            end
         end
      end
      return pick;
   endfunction

endpackage

// File: rtl/ami_rr_arb.sv
// Generic N-way round-robin picker: combinational valid/index from a request
// vector and a priority pointer.
import ami_pkg::*;

module ami_rr_arb #(
   parameter  int N  = 4,
   localparam int IW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic          valid,
   output logic [IW-1:0] idx
);

   logic [RR_MAXN-1:0] req_ext;

   always_comb begin
      req_ext        = '0;
      req_ext[N-1:0] = req;
      valid          = |req;
      idx            = IW'(rr_pick(req_ext, int'(ptr), N));
   end

endmodule

// File: rtl/ami_rd_arb.sv
// N-requester AXI read scheduler: round-robin AR arbitration with ARID tagging,
// per-requester outstanding-burst limit and RID-based R steering.
// Optional watchdog enabled by defining AMI_RD_ARB_WDOG_EN.
import ami_pkg::*;

module ami_rd_arb #(
   parameter  int NREQ       = 4,
   parameter  int AXI_IW     = 8,
   parameter  int AXI_AW     = 32,
   parameter  int AXI_LW     = 8,
   parameter  int AXI_SW     = 3,
   parameter  int AXI_BURSTW = 2,
   parameter  int AXI_DW     = 128,
   parameter  int AXI_RRESPW = 2,
   parameter  int MAX_OST    = 4,
`ifdef AMI_RD_ARB_WDOG_EN
   parameter  int WDOG_CYC   = 1024,
`endif
   localparam int IXW        = $clog2(NREQ),
   localparam int RIW        = AXI_IW - IXW,
   localparam int OCW        = $clog2(MAX_OST + 1)
) (
   input  logic                       usr_clk,
   input  logic                       usr_reset_n,
   input  logic [NREQ*RIW-1:0]        req_arid,
   input  logic [NREQ*AXI_AW-1:0]     req_araddr,
   input  logic [NREQ*AXI_LW-1:0]     req_arlen,
   input  logic [NREQ*AXI_SW-1:0]     req_arsize,
   input  logic [NREQ*AXI_BURSTW-1:0] req_arburst,
   input  logic [NREQ-1:0]            req_arvalid,
   output logic [NREQ-1:0]            req_arready,
   output logic [RIW-1:0]             req_rid,
   output logic [AXI_DW-1:0]          req_rdata,
   output logic [AXI_RRESPW-1:0]      req_rresp,
   output logic                       req_rlast,
   output logic [NREQ-1:0]            req_rvalid,
   input  logic [NREQ-1:0]            req_rready,
   output logic [AXI_IW-1:0]          usr_arid,
   output logic [AXI_AW-1:0]          usr_araddr,
   output logic [AXI_LW-1:0]          usr_arlen,
   output logic [AXI_SW-1:0]          usr_arsize,
   output logic [AXI_BURSTW-1:0]      usr_arburst,
   output logic                       usr_arvalid,
   input  logic                       usr_arready,
   input  logic [AXI_IW-1:0]          usr_rid,
   input  logic [AXI_DW-1:0]          usr_rdata,
   input  logic [AXI_RRESPW-1:0]      usr_rresp,
   input  logic                       usr_rlast,
   input  logic                       usr_rvalid,
   output logic                       usr_rready,
   output logic                       err_bad_id,
   output logic [NREQ*OCW-1:0]        ost_cnt
`ifdef AMI_RD_ARB_WDOG_EN
   ,
   output logic [NREQ-1:0]            wdog_to
`endif
);

   arb_state_t       state;
   logic [IXW-1:0]   rr_ptr;
   logic [IXW-1:0]   sel;
   logic [OCW-1:0]   ost [NREQ];
   logic [NREQ-1:0]  elig;
   logic [NREQ-1:0]  ost_inc;
   logic [NREQ-1:0]  ost_dec;
   logic [NREQ-1:0]  r_deliver;
   logic             zero_last;
   logic             pick_valid;
   logic [IXW-1:0]   pick_idx;
   logic             grant;
   logic             ar_fire;
   logic [IXW-1:0]   r_idx;
   logic             r_idx_ok;
   logic             r_fire_last;

   always_comb begin
      for (int i = 0; i < NREQ; i++) begin
         elig[i] = req_arvalid[i] && (ost[i] < OCW'(MAX_OST));
      end
   end

   ami_rr_arb #(.N(NREQ)) u_rr (
      .req   (elig),
      .ptr   (rr_ptr),
      .valid (pick_valid),
      .idx   (pick_idx)
   );

   // Acceptance is zero-cycle: the pick's ready pulses while its payload is captured.
   assign grant = usr_reset_n && (state == ARB) && pick_valid;

   always_comb begin
      req_arready = '0;
      if (grant) req_arready[pick_idx] = 1'b1;
   end

   assign usr_arvalid = (state == ISSUE);
   assign ar_fire     = usr_arvalid && usr_arready;

   always_ff @(posedge usr_clk or negedge usr_reset_n) begin
      if (!usr_reset_n) begin
         state       <= ARB;
         rr_ptr      <= '0;
         sel         <= '0;
         usr_arid    <= '0;
         usr_araddr  <= '0;
         usr_arlen   <= '0;
         usr_arsize  <= '0;
         usr_arburst <= '0;
      end else begin
         case (state)
            ARB: begin
               if (pick_valid) begin
                  sel         <= pick_idx;
                  usr_arid    <= {pick_idx, req_arid[pick_idx*RIW +: RIW]};
                  usr_araddr  <= req_araddr[pick_idx*AXI_AW +: AXI_AW];
                  usr_arlen   <= req_arlen[pick_idx*AXI_LW +: AXI_LW];
                  usr_arsize  <= req_arsize[pick_idx*AXI_SW +: AXI_SW];
                  usr_arburst <= req_arburst[pick_idx*AXI_BURSTW +: AXI_BURSTW];
                  state       <= ISSUE;
               end
            end
            ISSUE: begin
               if (usr_arready) begin
                  rr_ptr <= (sel == IXW'(NREQ - 1)) ? '0 : sel + IXW'(1);
                  state  <= ARB;
               end
            end
            default: state <= ARB;
         endcase
      end
   end

   assign r_idx     = usr_rid[AXI_IW-1:RIW];
   assign r_idx_ok  = (int'(r_idx) < NREQ);
   assign req_rid   = usr_rid[RIW-1:0];
   assign req_rdata = usr_rdata;
   assign req_rresp = usr_rresp;
   assign req_rlast = usr_rlast;

   // Beats with an out-of-range index are sunk so the shared channel never stalls.
   always_comb begin
      req_rvalid = '0;
      usr_rready = 1'b1;
      if (r_idx_ok) begin
         req_rvalid[r_idx] = usr_rvalid;
         usr_rready        = req_rready[r_idx];
      end
   end

   assign r_fire_last = usr_rvalid && usr_rready && usr_rlast && r_idx_ok;

   always_comb begin
      zero_last = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         r_deliver[i] = usr_rvalid && usr_rready && r_idx_ok && (r_idx == IXW'(i));
         ost_inc[i]   = ar_fire && (sel == IXW'(i)) && (ost[i] < OCW'(MAX_OST));
         ost_dec[i]   = r_fire_last && (r_idx == IXW'(i)) && (ost[i] != '0);
         if (r_fire_last && (r_idx == IXW'(i)) && (ost[i] == '0)) zero_last = 1'b1;
      end
   end

   always_ff @(posedge usr_clk or negedge usr_reset_n) begin
      if (!usr_reset_n) begin
         for (int i = 0; i < NREQ; i++) ost[i] <= '0;
         err_bad_id <= 1'b0;
      end else begin
         for (int i = 0; i < NREQ; i++) begin
            if (ost_inc[i] && !ost_dec[i]) ost[i] <= ost[i] + OCW'(1);
            else if (ost_dec[i] && !ost_inc[i]) ost[i] <= ost[i] - OCW'(1);
         end
         if ((usr_rvalid && !r_idx_ok) || zero_last) err_bad_id <= 1'b1;
      end
   end

   always_comb begin
      for (int i = 0; i < NREQ; i++) ost_cnt[i*OCW +: OCW] = ost[i];
   end

`ifdef AMI_RD_ARB_WDOG_EN
   localparam int WCW = $clog2(WDOG_CYC + 1);

   logic [WCW-1:0] wdog_cnt [NREQ];

   // Counts idle cycles per requester while it has bursts in flight.
   always_ff @(posedge usr_clk or negedge usr_reset_n) begin
      if (!usr_reset_n) begin
         for (int i = 0; i < NREQ; i++) wdog_cnt[i] <= '0;
         wdog_to <= '0;
      end else begin
         for (int i = 0; i < NREQ; i++) begin
            if (r_deliver[i] || ost[i] == '0) wdog_cnt[i] <= '0;
            else if (wdog_cnt[i] != WCW'(WDOG_CYC)) wdog_cnt[i] <= wdog_cnt[i] + WCW'(1);
            if (wdog_cnt[i] == WCW'(WDOG_CYC)) wdog_to[i] <= 1'b1;
         end
      end
   end
`endif

endmodule
